jzjpcc_imem_arbiter: RTL
========================

# jzjpcc_imem_arbiter

Shares the single synchronous instruction SRAM port between the fetch stage and a debug/loader requester. Sits between the fetch stage's latch-address output and the SRAM address/write port. When debug wins it stalls fetch, then requests a decode flush for the cycle the SRAM returns debug data. A bounded-starvation policy ensures both sides make progress.

## Interface
- PC_MAX_B, 15: highest word-address bit; addresses are [PC_MAX_B:2].
- STARVE_LIMIT, 4: consecutive cycles a pending debug request may be refused before it is forced through (1..15).

- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- fetchAddress  in  [PC_MAX_B:2]  address fetch wants latched this edge
- fetchStalled  in  1  hazard unit is already stalling fetch this cycle (free slot)
- stallFetchArb  out  1  fetch must not advance PC this edge (ORed into fetch stall)
- flushDecodeArb  out  1  decode must take nop this edge (ORed into decode flush)
- dbgReq  in  1  debug access pending; address/data/write held stable until dbgAck
- dbgWrite  in  1  1 = write, 0 = read
- dbgAddress  in  [PC_MAX_B:2]  debug word address
- dbgWriteData  in  32  write data
- dbgAck  out  1  one-cycle pulse: access issued at this edge
- dbgReadValid  out  1  one-cycle pulse: dbgReadData valid
- dbgReadData  out  32  read data, 0 when dbgReadValid low
- memAddress  out  [PC_MAX_B:2]  SRAM address to latch
- memWriteEnable  out  1  SRAM write strobe
- memWriteData  out  32  SRAM write data
- memReadData  in  32  SRAM output (registered inside SRAM)

## Operation
- States: FETCH (fetch owns port), RESP (SRAM output holds debug-access result).
- grant = (state==FETCH) & dbgReq & (fetchStalled | starveCount==STARVE_LIMIT); combinational.
- grant: memAddress=dbgAddress, memWriteEnable=dbgWrite, dbgAck=1, stallFetchArb=1; next state RESP.
- No grant: memAddress=fetchAddress, memWriteEnable=0, stallFetchArb=0.
- RESP: port returns to fetch (memAddress=fetchAddress); flushDecodeArb=1; dbgReadValid=~lastWasWrite, dbgReadData=memReadData; next state FETCH unconditionally. No grant in RESP (guarantees fetch one slot between debug accesses).
- starveCount: cleared on grant or when dbgReq low; increments each FETCH cycle with dbgReq high and no grant; saturates at STARVE_LIMIT; held in RESP. Width $clog2(STARVE_LIMIT+1).
- memWriteData = dbgWriteData always (qualified by memWriteEnable).
- Flush issued for writes too (read-during-write output undefined).

## Timing
- Reset (reset_n low, any time, mid-access included): state=FETCH, starveCount=0, lastWasWrite=0; all outputs combinationally yield memAddress=fetchAddress, memWriteEnable=0, stallFetchArb=0, flushDecodeArb=0, dbgAck=0, dbgReadValid=0, dbgReadData=0. An access in flight at reset produces no dbgReadValid.
- Read latency: grant at edge E0, dbgReadValid in cycle after E0 (sampled at E1).
- Cost to fetch: one lost address slot per access; fetch re-presents same address at E1 because PC held at E0.
- Fetch-only worst case: dbgReq continuously high, fetchStalled low -> one grant every STARVE_LIMIT+2 cycles.
- dbgReq dropped before ack: counter clears, no access.

## Structure
- Package jzjpcc_imem_arb_pkg: state enum (FETCH, RESP), STARVE_LIMIT bounds check constants.
- Sub-module jzjpcc_sat_counter (parameterised saturating counter with clear/enable) for starveCount.

## Test plan
- Reset asserted with dbgReq=1, dbgAddress=0x10 -> no ack, memAddress=fetchAddress, all strobes 0.
- STARVE_LIMIT=4, dbgReq read 0x20, fetchStalled=0 -> dbgAck on 5th cycle, memAddress=0x20, stallFetchArb=1; next cycle dbgReadValid=1, dbgReadData=SRAM[0x20], flushDecodeArb=1.
- fetchStalled=1 with dbgReq write 0x24 data 0xDEADBEEF -> grant same cycle, memWriteEnable=1, next cycle flushDecodeArb=1, dbgReadValid=0.
- Back-to-back debug requests with fetchStalled=1 -> grants never in consecutive cycles; RESP cycle always drives fetchAddress.
- reset_n low during RESP -> dbgReadValid and flushDecodeArb drop immediately; after release, state FETCH, count 0.
- dbgReq pulses 2 cycles then drops -> counter returns to 0, no dbgAck.

Source files
------------

// File: rtl/jzjpcc_imem_arb_pkg.sv
// Shared types and constants for the instruction-SRAM arbiter.
//   arb_state_t      : ownership state of the SRAM port
//   StarveLimitMin/Max: legal range for the arbiter's STARVE_LIMIT parameter
package jzjpcc_imem_arb_pkg;

    typedef enum logic {
        StFetch = 1'b0,  // fetch owns the SRAM port
        StResp  = 1'b1   // SRAM output holds the result of a debug access
    } arb_state_t;

    localparam int unsigned StarveLimitMin = 1;
    localparam int unsigned StarveLimitMax = 15;

endpackage

// File: rtl/jzjpcc_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset (count -> 0)
//   clear   : synchronous clear, wins over enable
//   enable  : increment by one unless already at Max
//   count   : current value, never exceeds Max
module jzjpcc_sat_counter #(
    parameter int unsigned Width = 3,
    parameter int unsigned Max   = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    output logic [Width-1:0] count
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != Width'(Max))) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/jzjpcc_imem_arbiter.sv
// Arbitrates the single synchronous instruction-SRAM port between fetch and a
// debug/loader requester. A debug grant stalls fetch for one edge; the
// following cycle flushes decode while the SRAM returns the debug result.
// A starvation counter forces a pending debug access through after
// STARVE_LIMIT refused cycles.
//   clock, reset_n                 : clock, async active-low reset
//   fetchAddress, fetchStalled     : fetch-side address and hazard stall
//   stallFetchArb, flushDecodeArb  : pipeline control back to fetch/decode
//   dbgReq/Write/Address/WriteData : debug request, held until dbgAck
//   dbgAck, dbgReadValid/ReadData  : debug handshake and read return
//   memAddress/WriteEnable/WriteData, memReadData : SRAM port
module jzjpcc_imem_arbiter
    import jzjpcc_imem_arb_pkg::*;
#(
    parameter int unsigned PC_MAX_B     = 15,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [PC_MAX_B:2]   fetchAddress,
    input  logic                fetchStalled,
    output logic                stallFetchArb,
    output logic                flushDecodeArb,
    input  logic                dbgReq,
    input  logic                dbgWrite,
    input  logic [PC_MAX_B:2]   dbgAddress,
    input  logic [31:0]         dbgWriteData,
    output logic                dbgAck,
    output logic                dbgReadValid,
    output logic [31:0]         dbgReadData,
    output logic [PC_MAX_B:2]   memAddress,
    output logic                memWriteEnable,
    output logic [31:0]         memWriteData,
    input  logic [31:0]         memReadData
);

    localparam int unsigned CountWidth = $clog2(STARVE_LIMIT + 1);

    if ((STARVE_LIMIT < StarveLimitMin) || (STARVE_LIMIT > StarveLimitMax)) begin : gen_bad_limit
        $error("STARVE_LIMIT out of range");
    end

    arb_state_t            state_q, state_d;
    logic                  last_was_write_q, last_was_write_d;
    logic [CountWidth-1:0] starve_count;
    logic                  in_fetch, in_resp, grant;
    logic                  count_clear, count_enable;

    assign in_fetch = (state_q == StFetch);
    assign in_resp  = (state_q == StResp);

    // Gated by reset_n so nothing is granted while reset is held.
    assign grant = reset_n & in_fetch & dbgReq &
                   (fetchStalled | (starve_count == CountWidth'(STARVE_LIMIT)));

    // Counter only moves in FETCH; in RESP it was already cleared by the grant.
    assign count_clear  = grant | (in_fetch & ~dbgReq);
    assign count_enable = in_fetch & dbgReq & ~grant;

    jzjpcc_sat_counter #(
        .Width (CountWidth),
        .Max   (STARVE_LIMIT)
    ) u_starve_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (count_clear),
        .enable  (count_enable),
        .count   (starve_count)
    );

    always_comb begin
        state_d          = StFetch;
        last_was_write_d = last_was_write_q;
        if (grant) begin
            state_d          = StResp;
            last_was_write_d = dbgWrite;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= StFetch;
            last_was_write_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            last_was_write_q <= last_was_write_d;
        end
    end

    always_comb begin
        memAddress     = fetchAddress;
        memWriteEnable = 1'b0;
        memWriteData   = dbgWriteData;
        stallFetchArb  = 1'b0;
        flushDecodeArb = 1'b0;
        dbgAck         = 1'b0;
        dbgReadValid   = 1'b0;
        dbgReadData    = '0;
        if (grant) begin
            memAddress     = dbgAddress;
            memWriteEnable = dbgWrite;
            stallFetchArb  = 1'b1;
            dbgAck         = 1'b1;
        end
        if (in_resp && reset_n) begin
            // Flush even after writes: read-during-write output is undefined.
            flushDecodeArb = 1'b1;
            if (!last_was_write_q) begin
                dbgReadValid = 1'b1;
                dbgReadData  = memReadData;
            end
        end
    end

endmodule
